// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared defaults and slot payload record for the CDB arbiter
package cdb_pkg;

  localparam int CDB_NUM_REQ = 6;
  localparam int CDB_NUM_CDB = 4;
  localparam int CDB_IDX_W   = 4;
  localparam int CDB_DATA_W  = 16;
  localparam int CDB_ID_W    = (CDB_NUM_REQ > 1) ? $clog2(CDB_NUM_REQ) : 1;

  typedef struct packed {
    logic                  valid;
    logic [CDB_IDX_W-1:0]  index;
    logic [CDB_DATA_W-1:0] value;
  } cdb_slot_t;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - rotated-priority multi-grant selector, purely combinational
import cdb_pkg::*;

module rr_select #(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int NUM_CDB = CDB_NUM_CDB,
  parameter int ID_W    = CDB_ID_W
) (
  input  logic [NUM_REQ-1:0]      valid,
  input  logic [ID_W-1:0]         rr_ptr,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_CDB*ID_W-1:0] slot_id,
  output logic [ID_W-1:0]         last_id
);

  // Walk requesters starting at rr_ptr; the n-th hit fills slot n until slots run out.
  always_comb begin
    int pos;
    int n;
    grant   = '0;
    slot_id = '0;
    last_id = rr_ptr;
    pos     = 0;
    n       = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      pos = int'(rr_ptr) + o;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int q = 0; q < NUM_REQ; q++) begin
        if (q == pos && valid[q] && n < NUM_CDB) begin
          grant[q] = 1'b1;
          for (int s = 0; s < NUM_CDB; s++) begin
            if (s == n) slot_id[s*ID_W +: ID_W] = ID_W'(q);
          end
          last_id = ID_W'(q);
          n       = n + 1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - grants up to NUM_CDB functional-unit results per cycle onto the CDB
import cdb_pkg::*;

module cdb_arbiter #(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int NUM_CDB = CDB_NUM_CDB,
  parameter int IDX_W   = CDB_IDX_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]  req_index,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  output logic [NUM_CDB-1:0]        cdb_valid,
  output logic [NUM_CDB*IDX_W-1:0]  cdb_index,
  output logic [NUM_CDB*DATA_W-1:0] cdb_value,
  output logic [15:0]               bcast_count
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]         rr_ptr;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_CDB*ID_W-1:0] slot_id;
  logic [ID_W-1:0]         last_id;
  logic [15:0]             k;
  logic [NUM_CDB-1:0]        nxt_valid;
  logic [NUM_CDB*IDX_W-1:0]  nxt_index;
  logic [NUM_CDB*DATA_W-1:0] nxt_value;

  // Masking the requests (not the grants) keeps rr_ptr and the count frozen on hold/rst.
  rr_select #(
    .NUM_REQ (NUM_REQ),
    .NUM_CDB (NUM_CDB),
    .ID_W    (ID_W)
  ) u_rr_select (
    .valid   (req_valid & {NUM_REQ{~(hold | rst)}}),
    .rr_ptr  (rr_ptr),
    .grant   (grant),
    .slot_id (slot_id),
    .last_id (last_id)
  );

  assign req_ready = grant;

  always_comb begin
    k         = '0;
    nxt_valid = '0;
    nxt_index = '0;
    nxt_value = '0;
    for (int r = 0; r < NUM_REQ; r++) k = k + 16'(grant[r]);
    for (int s = 0; s < NUM_CDB; s++) begin
      if (16'(s) < k) begin
        nxt_valid[s] = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
          if (slot_id[s*ID_W +: ID_W] == ID_W'(r)) begin
            nxt_index[s*IDX_W +: IDX_W]   = req_index[r*IDX_W +: IDX_W];
            nxt_value[s*DATA_W +: DATA_W] = req_value[r*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      bcast_count <= '0;
      cdb_valid   <= '0;
      cdb_index   <= '0;
      cdb_value   <= '0;
    end else begin
      cdb_valid   <= nxt_valid;
      cdb_index   <= nxt_index;
      cdb_value   <= nxt_value;
      bcast_count <= bcast_count + k;
      if (k != 16'd0) begin
        rr_ptr <= (last_id == ID_W'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter against a queue-based reference model
module tb_cdb_arbiter;

  localparam int NR = 6;
  localparam int NC = 4;
  localparam int IW = 4;
  localparam int DW = 16;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*IW-1:0] req_index;
  logic [NR*DW-1:0] req_value;
  logic [NR-1:0]    req_ready;
  logic             hold;
  logic [NC-1:0]    cdb_valid;
  logic [NC*IW-1:0] cdb_index;
  logic [NC*DW-1:0] cdb_value;
  logic [15:0]      bcast_count;

  cdb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_index   (req_index),
    .req_value   (req_value),
    .req_ready   (req_ready),
    .hold        (hold),
    .cdb_valid   (cdb_valid),
    .cdb_index   (cdb_index),
    .cdb_value   (cdb_value),
    .bcast_count (bcast_count)
  );

  typedef struct {
    logic [NC-1:0]    v;
    logic [NC*IW-1:0] idx;
    logic [NC*DW-1:0] val;
    logic [15:0]      cnt;
    logic [2:0]       ptr;
  } exp_t;

  exp_t        sbq[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [IW-1:0] idx_a[NR];
  logic [DW-1:0] val_a[NR];
  int          m_ptr   = 0;
  logic [15:0] m_count = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic rand_payload();
    for (int r = 0; r < NR; r++) begin
      idx_a[r] = IW'($urandom);
      val_a[r] = DW'($urandom);
    end
  endtask

  // Drive one cycle (clk low), check same-cycle grants, queue the next-cycle broadcast.
  task automatic step(input logic [NR-1:0] mask, input logic h, input logic r);
    exp_t        e;
    int          granted[$];
    logic [NR-1:0] gm;
    req_valid = mask;
    hold      = h;
    rst       = r;
    for (int q = 0; q < NR; q++) begin
      req_index[q*IW +: IW] = idx_a[q];
      req_value[q*DW +: DW] = val_a[q];
    end
    #1;
    gm = '0;
    if (!h && !r) begin
      for (int o = 0; o < NR; o++) begin
        int q;
        q = (m_ptr + o) % NR;
        if (mask[q] && granted.size() < NC) begin
          granted.push_back(q);
          gm[q] = 1'b1;
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(gm));
    e.v   = '0;
    e.idx = '0;
    e.val = '0;
    if (r) begin
      m_ptr   = 0;
      m_count = 16'd0;
    end else begin
      for (int s = 0; s < granted.size(); s++) begin
        e.v[s]             = 1'b1;
        e.idx[s*IW +: IW]  = idx_a[granted[s]];
        e.val[s*DW +: DW]  = val_a[granted[s]];
      end
      if (granted.size() > 0) m_ptr = (granted[granted.size()-1] + 1) % NR;
      m_count = m_count + 16'(granted.size());
    end
    e.cnt = m_count;
    e.ptr = 3'(m_ptr);
    sbq.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("cdb_valid",   64'(cdb_valid),   64'(e.v));
        chk("cdb_index",   64'(cdb_index),   64'(e.idx));
        chk("cdb_value",   64'(cdb_value),   64'(e.val));
        chk("bcast_count", 64'(bcast_count), 64'(e.cnt));
        chk("rr_ptr",      64'(dut.rr_ptr),  64'(e.ptr));
      end
    end
  end

  initial begin
    req_valid = '0;
    req_index = '0;
    req_value = '0;
    hold      = 1'b0;
    rst       = 1'b1;
    #2;
    rand_payload(); step(6'h00, 1'b0, 1'b1);
    rand_payload(); step(6'h3f, 1'b0, 1'b1);

    rand_payload(); idx_a[0] = 4'd3; idx_a[2] = 4'd7;
    step(6'b000101, 1'b0, 1'b0);

    rand_payload(); step(6'h3f, 1'b0, 1'b1);
    rand_payload(); step(6'h3f, 1'b0, 1'b0);
    rand_payload(); step(6'h3f, 1'b0, 1'b0);
    rand_payload(); step(6'h3f, 1'b1, 1'b0);

    rand_payload(); idx_a[1] = 4'd9; idx_a[2] = 4'd9;
    step(6'b000110, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rand_payload();
      step(NR'($urandom), ($urandom % 8) == 0, ($urandom % 40) == 0);
    end

    // Climb to 16'hFFFF, finishing on requester 4 so the pointer lands on 5.
    while ((16'hFFFF - m_count) > 16'd4) begin
      rand_payload(); step(6'h3f, 1'b0, 1'b0);
    end
    while (m_count != 16'hFFFF) begin
      rand_payload(); step(6'b010000, 1'b0, 1'b0);
    end
    rand_payload(); step(6'b100000, 1'b0, 1'b0);
    rand_payload(); step(6'h00, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
